// File: rtl/hll_pkg.sv
// Shared types for the HyperLogLog bucket-update stage: FSM states and pipeline stage record.
// Bucket field is sized for the largest supported P; rank width is the kernel-wide default.
package hll_pkg;

  localparam int HLL_RANK_W = 5;
  localparam int HLL_P_MAX  = 16;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } hll_upd_state_t;

  typedef struct packed {
    logic [HLL_P_MAX-1:0]  bucket;
    logic [HLL_RANK_W-1:0] rank;
    logic                  valid;
  } hll_upd_t;

endpackage

// File: rtl/hll_reg_ram.sv
// Simple dual-port register array, 1 write + 1 read port; read data registered (1 cycle).
// No backpressure; read-during-write to the same address returns the old contents.
module hll_reg_ram #(
  parameter int AW = 14,
  parameter int DW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/hll_bucket_update.sv
// Per-bucket max-rank sketch: 2-cycle read-modify-write at 1 update/cycle, drain of 2^P entries via valid/ready.
// No upstream stall (drops flagged on drop_err); drain stalls on drain_ready. HLL_CLEAR_ON_DRAIN_EN zeroes drained entries.
module hll_bucket_update
  import hll_pkg::*;
#(
  parameter int P      = 14,
  parameter int RANK_W = HLL_RANK_W
) (
  input  logic              clk,
  input  logic              ap_rst_n,
  input  logic [P-1:0]      in_bucket,
  input  logic [RANK_W-1:0] in_rank,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              drop_err,
  input  logic              drain_start,
  output logic [RANK_W-1:0] drain_data,
  output logic              drain_valid,
  input  logic              drain_ready,
  output logic              drain_last,
  output logic [P:0]        zero_count,
  output logic              done
);

  hll_upd_state_t state_q, state_d;
  logic [P-1:0]   clear_addr_q;

  hll_upd_t          s1_q, s2_q;
  logic [RANK_W-1:0] s2_old_q;
  logic [RANK_W-1:0] s1_old, s2_new, s2_rank;
  logic              accept;

  logic              ram_we;
  logic [P-1:0]      ram_waddr, ram_raddr;
  logic [RANK_W-1:0] ram_wdata, ram_rdata, rd_dat;
  logic              byp_vld_q;
  logic [RANK_W-1:0] byp_dat_q;

  logic [P:0]        rd_ptr_q;
  logic              rd_pend_q;
  logic              out_vld_q, skid_vld_q;
  logic [RANK_W-1:0] out_dat_q, skid_dat_q;
  logic [P-1:0]      hs_cnt_q;
  logic [1:0]        occ;
  logic              pop, last_pop, issue, drain_go;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (&clear_addr_q) state_d = RUN;
      RUN:     if (drain_start) state_d = FLUSH;
      // Nothing is accepted in FLUSH, so S1 is empty next cycle; the last S2 write
      // overlaps the first drain read and is covered by the read bypass.
      FLUSH:   state_d = DRAIN;
      DRAIN:   if (last_pop) state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == RUN);
    drain_valid = out_vld_q;
    drain_data  = out_dat_q;
    drain_last  = out_vld_q & (&hs_cnt_q);
  end

  assign accept   = in_valid & in_ready;
  assign drain_go = drain_start & (state_q == RUN);

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      clear_addr_q <= '0;
      drop_err     <= 1'b0;
    end else begin
      if (state_q == CLEAR) clear_addr_q <= clear_addr_q + P'(1);
      if (in_valid && !in_ready) drop_err <= 1'b1;
    end
  end

  // ---------------- update pipeline ----------------
  assign rd_dat  = byp_vld_q ? byp_dat_q : ram_rdata;
  assign s2_rank = RANK_W'(s2_q.rank);
  assign s2_new  = (s2_rank > s2_old_q) ? s2_rank : s2_old_q;

  // S2 holds the only write not yet visible to the S1 read result.
  always_comb begin
    s1_old = rd_dat;
    if (s2_q.valid && (s2_q.bucket == s1_q.bucket)) s1_old = s2_new;
  end

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      s2_old_q <= '0;
    end else begin
      s1_q.valid  <= accept;
      s1_q.bucket <= HLL_P_MAX'(in_bucket);
      s1_q.rank   <= HLL_RANK_W'(in_rank);
      s2_q        <= s1_q;
      s2_old_q    <= s1_old;
    end
  end

  // ---------------- RAM ports ----------------
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (s2_q.valid) begin
      ram_we    = 1'b1;
      ram_waddr = s2_q.bucket[P-1:0];
      ram_wdata = s2_new;
    end else if (state_q == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clear_addr_q;
    end
`ifdef HLL_CLEAR_ON_DRAIN_EN
    else if (pop) begin
      ram_we    = 1'b1;
      ram_waddr = hs_cnt_q;
    end
`endif
  end

  assign ram_raddr = (state_q == DRAIN) ? rd_ptr_q[P-1:0] : in_bucket;

  // Write-first emulation: a same-address write in the read cycle wins.
  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      byp_vld_q <= 1'b0;
      byp_dat_q <= '0;
    end else begin
      byp_vld_q <= ram_we && (ram_waddr == ram_raddr);
      byp_dat_q <= ram_wdata;
    end
  end

  hll_reg_ram #(
    .AW (P),
    .DW (RANK_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // ---------------- drain ----------------
  assign pop      = out_vld_q & drain_ready;
  assign last_pop = pop & (&hs_cnt_q);
  assign occ      = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, rd_pend_q};
  // Reads in flight plus buffered entries never exceed output register + skid.
  assign issue    = (state_q == DRAIN) && !rd_ptr_q[P] && ((occ < 2'd2) || pop);

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_ptr_q   <= '0;
      rd_pend_q  <= 1'b0;
      hs_cnt_q   <= '0;
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
      zero_count <= '0;
      done       <= 1'b0;
    end else begin
      rd_pend_q <= issue;
      done      <= last_pop;
      if (drain_go) begin
        rd_ptr_q   <= '0;
        hs_cnt_q   <= '0;
        zero_count <= '0;
      end else if (issue) begin
        rd_ptr_q <= rd_ptr_q + (P+1)'(1);
      end
      if (pop) begin
        hs_cnt_q <= hs_cnt_q + P'(1);
        if (out_dat_q == '0) zero_count <= zero_count + (P+1)'(1);
        if (skid_vld_q) begin
          out_dat_q  <= skid_dat_q;
          skid_vld_q <= rd_pend_q;
          skid_dat_q <= rd_dat;
        end else begin
          out_vld_q <= rd_pend_q;
          out_dat_q <= rd_dat;
        end
      end else if (rd_pend_q) begin
        if (!out_vld_q) begin
          out_vld_q <= 1'b1;
          out_dat_q <= rd_dat;
        end else begin
          skid_vld_q <= 1'b1;
          skid_dat_q <= rd_dat;
        end
      end
    end
  end

endmodule

// File: tb/tb_hll_bucket_update.sv
// Directed + randomized bench for hll_bucket_update (P=4) against an array-of-maxima reference.
module tb_hll_bucket_update;

  logic       clk = 1'b0;
  logic       ap_rst_n;
  logic [3:0] in_bucket;
  logic [4:0] in_rank;
  logic       in_valid;
  logic       in_ready;
  logic       drop_err;
  logic       drain_start;
  logic [4:0] drain_data;
  logic       drain_valid;
  logic       drain_ready;
  logic       drain_last;
  logic [4:0] zero_count;
  logic       done;

  int n_cmp = 0;
  int n_mis = 0;
  int model [16];

  always #5 clk = ~clk;

  hll_bucket_update #(.P(4), .RANK_W(5)) dut (
    .clk         (clk),
    .ap_rst_n    (ap_rst_n),
    .in_bucket   (in_bucket),
    .in_rank     (in_rank),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .drop_err    (drop_err),
    .drain_start (drain_start),
    .drain_data  (drain_data),
    .drain_valid (drain_valid),
    .drain_ready (drain_ready),
    .drain_last  (drain_last),
    .zero_count  (zero_count),
    .done        (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_upd(input int b, input int r);
    if (r > model[b]) model[b] = r;
  endtask

  task automatic send(input int b, input int r);
    in_valid  = 1'b1;
    in_bucket = 4'(b);
    in_rank   = 5'(r);
    model_upd(b, r);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_ready_timing(input string tag);
    @(negedge clk);
    ap_rst_n = 1'b1;
    repeat (15) tick();
    check({tag, "_ready_at15"}, 32'(in_ready), 0);
    tick();
    check({tag, "_ready_at16"}, 32'(in_ready), 1);
  endtask

  // mode 0: ready always; 1: ready every third cycle; 2: random ready
  task automatic run_drain(input string tag, input int mode, input bit with_upd,
                           input int ub, input int ur, input bit poke_drop);
    int cyc, idx, first_v, last_c, done_c, done_n, exp_zc;
    logic       prev_stall;
    logic [4:0] held;
    if (with_upd) model_upd(ub, ur);
    exp_zc = 0;
    for (int i = 0; i < 16; i++) if (model[i] == 0) exp_zc++;
    drain_start = 1'b1;
    drain_ready = 1'b0;
    if (with_upd) begin
      in_valid  = 1'b1;
      in_bucket = 4'(ub);
      in_rank   = 5'(ur);
    end
    tick();
    drain_start = 1'b0;
    in_valid    = 1'b0;
    cyc = 1; idx = 0; first_v = -1; last_c = -1; done_c = -1; done_n = 0;
    prev_stall = 1'b0;
    held = '0;
    while (cyc < 200 && !(done_n > 0 && cyc > done_c + 3)) begin
      in_valid = poke_drop && (cyc == 1);
      if (poke_drop && cyc == 1) begin
        in_bucket = 4'd5;
        in_rank   = 5'd31;
      end
      drain_start = (mode == 1) && (cyc == 8);
      case (mode)
        0:       drain_ready = 1'b1;
        1:       drain_ready = (cyc % 3 == 0);
        default: drain_ready = 1'($urandom_range(0, 1));
      endcase
      if (prev_stall) begin
        check({tag, "_stall_vld"}, 32'(drain_valid), 1);
        check({tag, "_stall_dat"}, 32'(drain_data), 32'(held));
      end
      if (drain_valid && first_v < 0) first_v = cyc;
      if (done) begin
        done_n++;
        done_c = cyc;
      end
      if (drain_valid && drain_ready) begin
        if (idx < 16) check($sformatf("%s_dat[%0d]", tag, idx), 32'(drain_data), model[idx]);
        check($sformatf("%s_last[%0d]", tag, idx), 32'(drain_last), 32'(idx == 15));
        if (drain_last) last_c = cyc;
        idx++;
      end
      prev_stall = drain_valid && !drain_ready;
      held = drain_data;
      tick();
      cyc++;
    end
    in_valid    = 1'b0;
    drain_start = 1'b0;
    drain_ready = 1'b0;
    check({tag, "_entries"}, idx, 16);
    check({tag, "_done_pulses"}, done_n, 1);
    check({tag, "_zero_count"}, 32'(zero_count), exp_zc);
    if (mode == 0) begin
      check({tag, "_first_valid_cyc"}, first_v, 4);
      check({tag, "_last_cyc"}, last_c, 19);
      check({tag, "_done_cyc"}, done_c, 20);
    end
`ifdef HLL_CLEAR_ON_DRAIN_EN
    for (int i = 0; i < 16; i++) model[i] = 0;
`endif
  endtask

  initial begin
    int prev_b;
    for (int i = 0; i < 16; i++) model[i] = 0;
    ap_rst_n    = 1'b0;
    in_bucket   = '0;
    in_rank     = '0;
    in_valid    = 1'b0;
    drain_start = 1'b0;
    drain_ready = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_drain_valid", 32'(drain_valid), 0);
    check("rst_drain_last", 32'(drain_last), 0);
    check("rst_done", 32'(done), 0);
    check("rst_drop_err", 32'(drop_err), 0);
    check("rst_zero_count", 32'(zero_count), 0);

    check_ready_timing("boot");
    run_drain("empty", 0, 1'b0, 0, 0, 1'b0);

    send(3, 5); send(3, 2); send(3, 9);
    tick();
    run_drain("b3", 0, 1'b0, 0, 0, 1'b0);

    send(7, 4); send(7, 1); send(7, 6);
    send(8, 6); tick(); send(8, 4);
    send(9, 0);
    tick();
    run_drain("fwd_stall", 1, 1'b0, 0, 0, 1'b0);

    prev_b = 0;
    for (int i = 0; i < 40; i++) begin
      int b;
      if ($urandom_range(0, 3) == 0) begin
        tick();
      end else begin
        b = ($urandom_range(0, 1) == 1) ? prev_b : int'($urandom_range(0, 15));
        send(b, int'($urandom_range(0, 31)));
        prev_b = b;
      end
    end
    run_drain("rand", 2, 1'b1, 0, int'($urandom_range(1, 31)), 1'b0);

    check("drop_err_clean", 32'(drop_err), 0);
    send(2, 3);
    tick();
    run_drain("drop", 0, 1'b0, 0, 0, 1'b1);
    check("drop_err_set", 32'(drop_err), 1);
    run_drain("second", 2, 1'b0, 0, 0, 1'b0);

    drain_start = 1'b1;
    drain_ready = 1'b1;
    tick();
    drain_start = 1'b0;
    repeat (7) tick();
    check("mid_drain_valid", 32'(drain_valid), 1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("mid_rst_drain_valid", 32'(drain_valid), 0);
    check("mid_rst_in_ready", 32'(in_ready), 0);
    check("mid_rst_drop_err", 32'(drop_err), 0);
    check("mid_rst_zero_count", 32'(zero_count), 0);
    drain_ready = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 0;
    check_ready_timing("rearm");
    run_drain("after_rst", 0, 1'b0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
